// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg: definitions shared by the program-counter controller.
//   state_t / ST_*   : controller state encoding (RUN and the two vector-load
//                      states)
//   pc_sel_t / SEL_* : encodings of pc_in_sel for a redirect
//                      (pc_src = 1)
//   is_vec_state()   : true in either vector-load state
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN     = 2'd0;
  localparam state_t ST_VEC_RST = 2'd1;
  localparam state_t ST_VEC_INT = 2'd2;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t SEL_INT    = 2'b00;
  localparam pc_sel_t SEL_STACK  = 2'b01;
  localparam pc_sel_t SEL_BRANCH = 2'b10;
  localparam pc_sel_t SEL_RESET  = 2'b11;

  function automatic logic is_vec_state(input state_t s);
    return (s == ST_VEC_RST) || (s == ST_VEC_INT);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux: combinational selection of the next program counter. It
// assumes the cycle is not stalled. The controller applies stall itself.
//   state       : current controller state
//   pc_src      : 0 = sequential, 1 = redirect selected by pc_in_sel
//   pc_in_sel   : redirect source
//   int_pend    : an external interrupt is waiting
//   pc          : current PC
//   pc_plus_1   : pc + 1, wrapping
//   stack_addr  : return target
//   branch_addr : branch or jump target
//   mem_data    : vector contents read at vec_addr
//   pc_next     : PC value for the next unstalled cycle
// ---------------------------------------------------------------------------
module pc_next_mux
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  state_t            state,
  input  logic              pc_src,
  input  pc_sel_t           pc_in_sel,
  input  logic              int_pend,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus_1,
  input  logic [ADDR_W-1:0] stack_addr,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] mem_data,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    // NOTE: default first so every path assigns pc_next and no latch is inferred.
    pc_next = pc;
    unique case (state)
      ST_VEC_RST,
      ST_VEC_INT: pc_next = mem_data;
      ST_RUN: begin
        if (pc_src) begin
          // A soft reset or a software interrupt leaves the PC alone.
          // The vector state loads it on the following cycle.
          if (pc_in_sel == SEL_STACK)       pc_next = stack_addr;
          else if (pc_in_sel == SEL_BRANCH) pc_next = branch_addr;
        end else if (!int_pend) begin
          pc_next = pc_plus_1;
        end
      end
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl: program-counter register and the controller around it. It handles
// reset and interrupt vector loads, redirects, and a single pending external
// interrupt.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   stall         : hold PC, state, ret_addr and the vector access
//   pc_src        : 0 = sequential, 1 = redirect selected by pc_in_sel
//   pc_in_sel     : 00 sw interrupt, 01 stack, 10 branch, 11 soft reset
//   stack_addr    : return target (RET/RTI)
//   branch_addr   : branch or jump target
//   int_req       : external interrupt request, sampled every cycle
//   mem_data      : combinational read data at vec_addr
//   pc            : current PC (registered)
//   pc_plus_1     : pc + 1, wrapping
//   vec_rd        : high while in a vector-load state
//   vec_addr      : vector address being read, 0 otherwise
//   int_taken     : pulse on the cycle that commits RUN -> VEC_INT
//   ret_addr      : PC to push when an interrupt is taken (registered)
// ---------------------------------------------------------------------------
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned INT_VEC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              pc_src,
  input  logic [1:0]        pc_in_sel,
  input  logic [ADDR_W-1:0] stack_addr,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] mem_data,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_1,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              int_taken,
  output logic [ADDR_W-1:0] ret_addr
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] INT_ADDR   = ADDR_W'(INT_VEC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_next;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic              int_pend_q, int_pend_d;
  logic              int_taken_d;
  logic              pend_clr;

  assign pc_plus_1 = pc_q + ADDR_W'(1);

  pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
    .state       (state_q),
    .pc_src      (pc_src),
    .pc_in_sel   (pc_in_sel),
    .int_pend    (int_pend_q),
    .pc          (pc_q),
    .pc_plus_1   (pc_plus_1),
    .stack_addr  (stack_addr),
    .branch_addr (branch_addr),
    .mem_data    (mem_data),
    .pc_next     (pc_next)
  );

  always_comb begin
    state_d     = state_q;
    ret_addr_d  = ret_addr_q;
    int_taken_d = 1'b0;
    pend_clr    = 1'b0;
    pc_d        = stall ? pc_q : pc_next;
    if (!stall) begin
      unique case (state_q)
        ST_VEC_RST: state_d = ST_RUN;
        ST_VEC_INT: begin
          state_d  = ST_RUN;
          pend_clr = 1'b1;
        end
        ST_RUN: begin
          if (pc_src) begin
            // A redirect wins over a pending interrupt. The request
            // stays pending until a later sequential cycle.
            if (pc_in_sel == SEL_RESET) begin
              state_d = ST_VEC_RST;
            end else if (pc_in_sel == SEL_INT) begin
              state_d     = ST_VEC_INT;
              int_taken_d = 1'b1;
              ret_addr_d  = pc_plus_1;
            end
          end else if (int_pend_q) begin
            // The instruction at pc has not executed yet, so it is the
            // return point.
            state_d     = ST_VEC_INT;
            int_taken_d = 1'b1;
            ret_addr_d  = pc_q;
          end
        end
        default: state_d = ST_VEC_RST;  // recover from the unused encoding
      endcase
    end
    // A new request wins over the clear in the same cycle.
    int_pend_d = int_req | (int_pend_q & ~pend_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_VEC_RST;
      pc_q       <= '0;
      ret_addr_q <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_addr_q <= ret_addr_d;
      int_pend_q <= int_pend_d;
    end
  end

  always_comb begin
    vec_addr = '0;
    if (state_q == ST_VEC_RST)      vec_addr = RESET_ADDR;
    else if (state_q == ST_VEC_INT) vec_addr = INT_ADDR;
  end

  assign vec_rd    = is_vec_state(state_q);
  assign int_taken = int_taken_d;
  assign pc        = pc_q;
  assign ret_addr  = ret_addr_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_ctrl: self-checking bench for pc_ctrl (default parameters: 8-bit
// addresses, reset vector at 0, interrupt vector at 1). Directed scenarios
// compare against constant values. A randomized run compares against a
// behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_pc_ctrl;

  logic       clk, rst, stall, pc_src, int_req;
  logic [1:0] pc_in_sel;
  logic [7:0] stack_addr, branch_addr, mem_data;
  logic [7:0] pc, pc_plus_1, vec_addr, ret_addr;
  logic       vec_rd, int_taken;

  logic [7:0] mem [256];
  assign mem_data = mem[vec_addr];

  int vecs = 0;
  int errs = 0;

  pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_src      (pc_src),
    .pc_in_sel   (pc_in_sel),
    .stack_addr  (stack_addr),
    .branch_addr (branch_addr),
    .int_req     (int_req),
    .mem_data    (mem_data),
    .pc          (pc),
    .pc_plus_1   (pc_plus_1),
    .vec_rd      (vec_rd),
    .vec_addr    (vec_addr),
    .int_taken   (int_taken),
    .ret_addr    (ret_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. The mode says what the controller is doing:
  // running, or fetching the reset or interrupt target from memory.
  typedef enum {M_RUN, M_LOAD_RESET, M_LOAD_INT} mode_e;
  mode_e      m_mode;
  logic [7:0] m_pc, m_ret;
  bit         m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_LOAD_RESET; m_pc = 8'h00; m_ret = 8'h00; m_pend = 0;
    end else begin
      if (!stall) begin
        if (m_mode == M_LOAD_RESET) begin
          m_pc = mem[0]; m_mode = M_RUN;
        end else if (m_mode == M_LOAD_INT) begin
          m_pc = mem[1]; m_mode = M_RUN; m_pend = 0;
        end else if (pc_src) begin
          case (pc_in_sel)
            2'd1: m_pc = stack_addr;
            2'd2: m_pc = branch_addr;
            2'd3: m_mode = M_LOAD_RESET;
            default: begin m_ret = 8'((m_pc + 1) % 256); m_mode = M_LOAD_INT; end
          endcase
        end else if (m_pend) begin
          m_ret = m_pc; m_mode = M_LOAD_INT;
        end else begin
          m_pc = 8'((m_pc + 1) % 256);
        end
      end
      if (int_req) m_pend = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; pc_src = 0; pc_in_sel = 2'b00; int_req = 0;
    stack_addr = 8'h00; branch_addr = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem[0] = 8'h3C; mem[1] = 8'h80;
    rst = 0;
    #2 rst = 1;
    #1;
    vecs++; if (vec_rd !== 1'b1) begin errs++; $display("FAIL reset_vec_rd got=%b exp=1", vec_rd); end
    vecs++; if (vec_addr !== 8'h00) begin errs++; $display("FAIL reset_vec_addr got=%h exp=00", vec_addr); end
    vecs++; if (pc !== 8'h00) begin errs++; $display("FAIL reset_pc got=%h exp=00", pc); end
    vecs++; if (ret_addr !== 8'h00) begin errs++; $display("FAIL reset_ret got=%h exp=00", ret_addr); end
    vecs++; if (int_taken !== 1'b0) begin errs++; $display("FAIL reset_int_taken got=%b exp=0", int_taken); end
    tick(); tick();
    rst = 0;
    #1;
    vecs++; if (vec_rd !== 1'b1 || pc !== 8'h00) begin errs++; $display("FAIL reset_release vec_rd=%b pc=%h exp 1/00", vec_rd, pc); end
    tick();
    vecs++; if (pc !== 8'h3C || vec_rd !== 1'b0) begin errs++; $display("FAIL reset_load pc=%h vec_rd=%b exp 3C/0", pc, vec_rd); end
    tick();
    vecs++; if (pc !== 8'h3D || pc_plus_1 !== 8'h3E) begin errs++; $display("FAIL reset_seq pc=%h pc_plus_1=%h exp 3D/3E", pc, pc_plus_1); end
  endtask

  task automatic test_wrap();
    pc_src = 1; pc_in_sel = 2'b10; branch_addr = 8'hFE;
    tick();
    vecs++; if (pc !== 8'hFE) begin errs++; $display("FAIL wrap_setup pc=%h exp=FE", pc); end
    pc_src = 0;
    tick();
    vecs++; if (pc !== 8'hFF || pc_plus_1 !== 8'h00) begin errs++; $display("FAIL wrap_ff pc=%h pc_plus_1=%h exp FF/00", pc, pc_plus_1); end
    tick();
    vecs++; if (pc !== 8'h00 || pc_plus_1 !== 8'h01) begin errs++; $display("FAIL wrap_00 pc=%h pc_plus_1=%h exp 00/01", pc, pc_plus_1); end
  endtask

  task automatic test_redirects();
    pc_src = 1; pc_in_sel = 2'b10; branch_addr = 8'h30;
    tick();
    vecs++; if (pc !== 8'h30) begin errs++; $display("FAIL redir_branch pc=%h exp=30", pc); end
    pc_in_sel = 2'b01; stack_addr = 8'h20;
    tick();
    vecs++; if (pc !== 8'h20) begin errs++; $display("FAIL redir_stack pc=%h exp=20", pc); end
    pc_in_sel = 2'b11;
    tick();
    vecs++; if (vec_rd !== 1'b1 || vec_addr !== 8'h00 || pc !== 8'h20) begin
      errs++; $display("FAIL redir_softrst vec_rd=%b vec_addr=%h pc=%h exp 1/00/20", vec_rd, vec_addr, pc);
    end
    pc_src = 0;
    tick();
    vecs++; if (pc !== 8'h3C) begin errs++; $display("FAIL redir_softrst_load pc=%h exp=3C", pc); end
  endtask

  task automatic test_ext_int();
    pc_src = 1; pc_in_sel = 2'b10; branch_addr = 8'h44;
    tick();
    pc_src = 0; int_req = 1;
    tick();
    int_req = 0;
    #1;
    vecs++; if (pc !== 8'h45 || int_taken !== 1'b1) begin errs++; $display("FAIL ext_take pc=%h int_taken=%b exp 45/1", pc, int_taken); end
    tick();
    vecs++; if (ret_addr !== 8'h45 || vec_addr !== 8'h01 || vec_rd !== 1'b1 || pc !== 8'h45 || int_taken !== 1'b0) begin
      errs++; $display("FAIL ext_vec ret=%h vec_addr=%h vec_rd=%b pc=%h int_taken=%b exp 45/01/1/45/0",
                       ret_addr, vec_addr, vec_rd, pc, int_taken);
    end
    tick();
    vecs++; if (pc !== 8'h80 || vec_rd !== 1'b0 || int_taken !== 1'b0) begin
      errs++; $display("FAIL ext_load pc=%h vec_rd=%b int_taken=%b exp 80/0/0", pc, vec_rd, int_taken);
    end
  endtask

  task automatic test_collision();
    int_req = 1;
    tick();
    int_req = 0; pc_src = 1; pc_in_sel = 2'b10; branch_addr = 8'h50;
    #1;
    vecs++; if (int_taken !== 1'b0) begin errs++; $display("FAIL coll_deferred int_taken=%b exp=0", int_taken); end
    tick();
    vecs++; if (pc !== 8'h50) begin errs++; $display("FAIL coll_branch pc=%h exp=50", pc); end
    pc_src = 0;
    #1;
    vecs++; if (int_taken !== 1'b1) begin errs++; $display("FAIL coll_take int_taken=%b exp=1", int_taken); end
    tick();
    vecs++; if (ret_addr !== 8'h50 || vec_addr !== 8'h01) begin errs++; $display("FAIL coll_ret ret=%h vec_addr=%h exp 50/01", ret_addr, vec_addr); end
    tick();
    vecs++; if (pc !== 8'h80) begin errs++; $display("FAIL coll_load pc=%h exp=80", pc); end
  endtask

  task automatic test_stall();
    mem[1] = 8'hA7;
    // Software interrupt from pc=80 enters the interrupt vector state.
    pc_src = 1; pc_in_sel = 2'b00;
    #1;
    vecs++; if (int_taken !== 1'b1) begin errs++; $display("FAIL stall_sw_take int_taken=%b exp=1", int_taken); end
    tick();
    vecs++; if (ret_addr !== 8'h81 || vec_addr !== 8'h01) begin errs++; $display("FAIL stall_sw_ret ret=%h vec_addr=%h exp 81/01", ret_addr, vec_addr); end
    pc_src = 0; stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++; if (pc !== 8'h80 || vec_rd !== 1'b1 || vec_addr !== 8'h01 || int_taken !== 1'b0) begin
        errs++; $display("FAIL stall_vec_hold[%0d] pc=%h vec_rd=%b vec_addr=%h int_taken=%b exp 80/1/01/0",
                         k, pc, vec_rd, vec_addr, int_taken);
      end
    end
    // Release on the commit cycle with a new request: the set wins over the clear.
    stall = 0; int_req = 1;
    tick();
    int_req = 0;
    #1;
    vecs++; if (pc !== 8'hA7 || int_taken !== 1'b1) begin errs++; $display("FAIL stall_release pc=%h int_taken=%b exp A7/1", pc, int_taken); end
    tick();
    vecs++; if (ret_addr !== 8'hA7) begin errs++; $display("FAIL stall_second_ret ret=%h exp=A7", ret_addr); end
    tick();
    // The pending interrupt must survive a stall in RUN.
    int_req = 1;
    tick();
    int_req = 0; stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++; if (pc !== 8'hA8 || int_taken !== 1'b0) begin
        errs++; $display("FAIL stall_run_hold[%0d] pc=%h int_taken=%b exp A8/0", k, pc, int_taken);
      end
    end
    stall = 0;
    #1;
    vecs++; if (int_taken !== 1'b1) begin errs++; $display("FAIL stall_run_take int_taken=%b exp=1", int_taken); end
    tick();
    vecs++; if (ret_addr !== 8'hA8) begin errs++; $display("FAIL stall_run_ret ret=%h exp=A8", ret_addr); end
    tick();
    vecs++; if (pc !== 8'hA7) begin errs++; $display("FAIL stall_run_load pc=%h exp=A7", pc); end
  endtask

  task automatic test_random();
    bit       exp_taken;
    bit [7:0] exp_vaddr;
    mem[0] = 8'($urandom); mem[1] = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      stall       = ($urandom_range(0, 3) == 0);
      pc_src      = ($urandom_range(0, 9) < 3);
      pc_in_sel   = 2'($urandom_range(0, 3));
      stack_addr  = 8'($urandom);
      branch_addr = 8'($urandom);
      int_req     = ($urandom_range(0, 9) == 0);
      #1;
      exp_taken = (m_mode == M_RUN) && !stall && (pc_src ? (pc_in_sel == 2'd0) : m_pend);
      exp_vaddr = (m_mode == M_LOAD_INT) ? 8'h01 : 8'h00;
      vecs++; if (pc !== m_pc) begin errs++; $display("FAIL rand_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
      vecs++; if (pc_plus_1 !== 8'((m_pc + 1) % 256)) begin errs++; $display("FAIL rand_pc_plus_1[%0d] got=%h exp=%h", i, pc_plus_1, 8'((m_pc + 1) % 256)); end
      vecs++; if (vec_rd !== (m_mode != M_RUN)) begin errs++; $display("FAIL rand_vec_rd[%0d] got=%b exp=%b", i, vec_rd, m_mode != M_RUN); end
      vecs++; if (vec_addr !== exp_vaddr) begin errs++; $display("FAIL rand_vec_addr[%0d] got=%h exp=%h", i, vec_addr, exp_vaddr); end
      vecs++; if (int_taken !== exp_taken) begin errs++; $display("FAIL rand_int_taken[%0d] got=%b exp=%b", i, int_taken, exp_taken); end
      vecs++; if (ret_addr !== m_ret) begin errs++; $display("FAIL rand_ret[%0d] got=%h exp=%h", i, ret_addr, m_ret); end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_redirects();
    test_ext_int();
    test_collision();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of all address/PC buses.
REQ-002 SHALL have parameter RESET_VEC, default 0: memory address holding the reset target.
REQ-003 SHALL have parameter INT_VEC, default 1: memory address holding the interrupt target.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  in  1  hold PC, state and vector access.
REQ-007 SHALL have port pc_src  in  1  0 = sequential, 1 = redirect per pc_in_sel.
REQ-008 SHALL have port pc_in_sel  in  2  00 software interrupt, 01 stack, 10 branch, 11 soft reset.
REQ-009 SHALL have port stack_addr  in  ADDR_W  return target (RET/RTI).
REQ-010 SHALL have port branch_addr  in  ADDR_W  branch/jump target.
REQ-011 SHALL have port int_req  in  1  external interrupt request, level-sampled.
REQ-012 SHALL have port mem_data  in  ADDR_W  combinational read data at vec_addr.
REQ-013 SHALL have port pc  out  ADDR_W  current PC, registered.
REQ-014 SHALL have port pc_plus_1  out  ADDR_W  pc+1 mod 2^ADDR_W, combinational.
REQ-015 SHALL have port vec_rd  out  1  vector read active, high in VEC_RST and VEC_INT.
REQ-016 SHALL have port vec_addr  out  ADDR_W  RESET_VEC in VEC_RST, INT_VEC in VEC_INT, else 0.
REQ-017 SHALL have port int_taken  out  1  one-cycle pulse on the cycle RUN->VEC_INT commits.
REQ-018 SHALL have port ret_addr  out  ADDR_W  registered PC to push when int_taken.

Function
REQ-019 SHALL implement states RUN, VEC_RST, VEC_INT.
REQ-020 SHALL in VEC_RST, !stall: pc <= mem_data, -> RUN.
REQ-021 SHALL in VEC_INT, !stall: pc <= mem_data, clear int_pend, -> RUN.
REQ-022 SHALL in RUN, !stall, pc_src=0, int_pend=0: pc <= pc+1; wrap 2^ADDR_W-1 -> 0.
REQ-023 SHALL in RUN, !stall, pc_src=1: sel 01 pc<=stack_addr; 10 pc<=branch_addr; 11 -> VEC_RST (pc unchanged); 00 -> VEC_INT with int_taken, ret_addr<=pc_plus_1.
REQ-024 SHALL in RUN, !stall, pc_src=0, int_pend=1: -> VEC_INT, int_taken=1, ret_addr<=pc, pc unchanged.
REQ-025 SHALL set int_pend on any cycle int_req=1 (including stall and vector states); only one request pending.
REQ-026 SHALL give set priority over clear when int_req=1 in the VEC_INT commit cycle.
REQ-027 SHALL defer a pending interrupt while pc_src=1 (redirect wins); int_pend held.
REQ-028 SHALL, when stall=1, hold pc, state, ret_addr; int_taken=0; vec_rd/vec_addr reflect state.
REQ-029 SHALL keep vector-load latency at exactly one unstalled cycle in a vector state.

Reset
REQ-030 SHALL on rst: pc=0, ret_addr=0, int_pend=0, int_taken=0, state=VEC_RST (vec_rd=1, vec_addr=RESET_VEC).
REQ-031 SHALL abort any operation when rst asserts mid-vector or mid-stall; no partial pc update.

Structure
REQ-032 SHALL place state enum and pc_in_sel encodings (SEL_INT, SEL_STACK, SEL_BRANCH, SEL_RESET) in shared package pc_ctrl_pkg.
REQ-033 SHALL isolate next-PC selection in sub-module pc_next_mux (combinational); pc_ctrl holds registers and FSM.

Verification
REQ-034 SHALL test reset: rst pulse, mem_data=8'h3C -> vec_rd=1, vec_addr=00 during VEC_RST; pc=3C one cycle after release, then 3D.
REQ-035 SHALL test wrap: pc=FF, pc_src=0 -> pc=00, pc_plus_1=01.
REQ-036 SHALL test redirects: sel=10 branch_addr=30 -> pc=30; sel=01 stack_addr=20 -> pc=20; sel=11 -> VEC_RST, vec_addr=00.
REQ-037 SHALL test external interrupt: pc=45, int_req pulse, mem_data=80 -> int_taken next cycle, ret_addr=45, vec_addr=01, then pc=80.
REQ-038 SHALL test collision: int_pend with sel=10 branch_addr=50 -> pc=50 first, then int_taken with ret_addr=50.
REQ-039 SHALL test stall: stall=1 for 3 cycles during VEC_INT with int_req pulse -> pc frozen, int_pend retained, vector loads after release, second interrupt taken next.
